// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited imem requests, in-order
// response FIFO toward decode, redirect flush. Optional macro IFETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter int                  INSTRSIZE = 32,
  parameter int                  ADDRSIZE  = 64,
  parameter logic [ADDRSIZE-1:0] RESET_PC  = '0,
  parameter int                  DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDRSIZE-1:0]  imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTRSIZE-1:0] imem_rsp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTRSIZE-1:0] instruction,
  output logic [ADDRSIZE-1:0]  instr_pc,
  input  logic                 redirect_valid,
  input  logic [ADDRSIZE-1:0]  redirect_pc,
  output logic                 fetch_misaligned
);

  localparam int                  PW      = $clog2(DEPTH);
  localparam int                  CW      = PW + 1;
  localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
  localparam logic [ADDRSIZE-1:0] PC_STEP = ADDRSIZE'(4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT
  } state_t;

  state_t               state, state_nxt;
  logic [ADDRSIZE-1:0]  pc, rsp_pc;
  logic [CW-1:0]        count, outstanding, discard;
  logic [PW-1:0]        wptr, rptr;
  logic [INSTRSIZE-1:0] fifo_instr [DEPTH];
  logic [ADDRSIZE-1:0]  fifo_pc    [DEPTH];

  logic [ADDRSIZE-1:0]  tgt_pc;
  logic                 tgt_misaligned;
  logic                 req_ok, req_hs, rsp_ok, push, pop;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v, input logic en);
    logic [CW-1:0] r;
    r = v;
    if (en && (v != '0)) r = v - CW'(1);
    return r;
  endfunction

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign tgt_pc         = redirect_pc;
  assign tgt_misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      misaligned_q <= tgt_misaligned;
    end
  end

  assign fetch_misaligned = misaligned_q;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign tgt_pc              = {redirect_pc[ADDRSIZE-1:2], 2'b00};
  assign tgt_misaligned      = 1'b0;
  assign fetch_misaligned    = 1'b0;
`endif

  // Request side: credits cover both buffered entries and responses still in flight
  assign req_ok         = (state == ST_FETCH) && !redirect_valid &&
                          ((count + outstanding) < DEPTH_C);
  assign imem_req_valid = req_ok;
  assign imem_addr      = pc;
  assign req_hs         = req_ok && imem_req_ready;

  // Response side: a response with nothing outstanding is ignored so counters cannot wrap
  assign rsp_ok = imem_rsp_valid && (outstanding != '0);
  assign push   = rsp_ok && (discard == '0) && !redirect_valid;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign instruction = instr_valid ? fifo_instr[rptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rptr]    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
    if (redirect_valid) state_nxt = tgt_misaligned ? ST_HALT : ST_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_hs) - CW'(rsp_ok);
      if (redirect_valid) begin
        pc      <= tgt_pc;
        rsp_pc  <= tgt_pc;
        count   <= '0;
        wptr    <= '0;
        rptr    <= '0;
        // discard is always a subset of outstanding, so every response still owed is stale
        discard <= outstanding - CW'(rsp_ok);
      end else begin
        if (req_hs) pc <= pc + PC_STEP;
        if (push) begin
          rsp_pc <= rsp_pc + PC_STEP;
          wptr   <= wptr + PW'(1);
        end
        if (pop) rptr <= rptr + PW'(1);
        count   <= count + CW'(push) - CW'(pop);
        discard <= sat_dec(discard, rsp_ok);
      end
    end
  end

  // FIFO payload carries no reset; outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wptr] <= imem_rsp_data;
      fifo_pc[wptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: fixed-latency memory model checks request
// addresses, a monitor checks every popped {instruction, pc} against queued expectations.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RPC = 64'h1000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_misaligned;

  instruction_fetch_unit #(
    .INSTRSIZE(32),
    .ADDRSIZE (64),
    .RESET_PC (RPC),
    .DEPTH    (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  int          vectors  = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          latency  = 1;
  int          budget   = 0;
  int          hs_count = 0;
  item_t       exp_q[$];
  logic [63:0] exp_addr[$];
  pend_t       pend[$];

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [63:0] a);
    exp_addr.push_back(a);
    exp_q.push_back('{mdata(a), a});
  endtask

  task automatic redirect(input logic [63:0] a);
    redirect_pc    = a;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_addr.size() != 0 || pend.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      vectors++;
      errors++;
      $display("FAIL %s: drain timeout, %0d outputs and %0d requests still expected",
               name, exp_q.size(), exp_addr.size());
    end
  endtask

  task automatic hold_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    budget         = 0;
    repeat (2) tick();
  endtask

  // Memory model: sampled on the falling edge, responses in order after `latency` cycles
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (pend.size() > 0 && pend[0].due == cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mdata(pend[0].addr);
          pend.delete(0);
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
        if (imem_req_valid && imem_req_ready) begin
          hs_count++;
          budget--;
          if (exp_addr.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_req: addr %h issued, none expected", imem_addr);
          end else begin
            check("imem_addr", imem_addr, exp_addr[0]);
            exp_addr.delete(0);
          end
          pend.push_back('{imem_addr, cyc + latency});
        end
      end
      @(posedge clk);
      #1;
      imem_req_ready = (budget > 0) && rst_n;
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_instr: pc %h instr %h popped, none expected",
                   instr_pc, instruction);
        end else begin
          check("instr_pc", instr_pc, exp_q[0].pc);
          check("instruction", 64'(instruction), 64'(exp_q[0].instr));
          exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int h0;
    rst_n       = 1'b0;
    redirect_pc = '0;
    hold_reset();

    // Reset values
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_instr_pc", instr_pc, 64'd0);
    check("rst_misaligned", 64'(fetch_misaligned), 64'd0);

    // Sequential fetch, latency 1, decode always ready
    latency     = 1;
    budget      = 3;
    instr_ready = 1'b1;
    expect_fetch(64'h1000);
    expect_fetch(64'h1004);
    expect_fetch(64'h1008);
    rst_n = 1'b1;
    check("idle_no_req", 64'(imem_req_valid), 64'd0);
    k = 0;
    while (!instr_valid && k < 10) begin
      tick();
      k++;
    end
    check("first_valid_latency", 64'(k), 64'd3);
    drain("seq_fetch");

    // Decode stalled: credits stop requests at DEPTH, then in-order drain
    hold_reset();
    latency = 1;
    budget  = 2;
    expect_fetch(64'h1000);
    expect_fetch(64'h1004);
    h0    = hs_count;
    rst_n = 1'b1;
    repeat (10) tick();
    check("credit_req_count", 64'(hs_count - h0), 64'd2);
    check("credit_stall", 64'(imem_req_valid), 64'd0);
    check("fifo_full_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    drain("backpressure");

    // Redirect with two requests in flight, latency 3: both stale responses dropped
    hold_reset();
    latency     = 3;
    budget      = 2;
    instr_ready = 1'b1;
    exp_addr.push_back(64'h1000);
    exp_addr.push_back(64'h1004);
    h0    = hs_count;
    rst_n = 1'b1;
    k     = 0;
    while ((hs_count - h0) < 2 && k < 20) begin
      tick();
      k++;
    end
    check("inflight_reqs", 64'(hs_count - h0), 64'd2);
    budget = 2;
    expect_fetch(64'h2000);
    expect_fetch(64'h2004);
    redirect(64'h2000);
    check("redirect_flush_valid", 64'(instr_valid), 64'd0);
    drain("redirect_inflight");

    // Redirect coinciding with a pop attempt and a response arrival
    hold_reset();
    latency = 1;
    budget  = 2;
    exp_addr.push_back(64'h1000);
    exp_addr.push_back(64'h1004);
    rst_n = 1'b1;
    k     = 0;
    while (!instr_valid && k < 10) begin
      tick();
      k++;
    end
    check("pre_redirect_head", instr_pc, 64'h1000);
    instr_ready = 1'b1;
    budget      = 1;
    expect_fetch(64'h3000);
    redirect(64'h3000);
    check("same_cycle_flush_valid", 64'(instr_valid), 64'd0);
    drain("redirect_pop_rsp");

    // PC wrap at the top of the address space
    latency = 1;
    budget  = 2;
    expect_fetch(64'hFFFF_FFFF_FFFF_FFFC);
    expect_fetch(64'h0);
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    drain("pc_wrap");

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Misaligned redirect halts fetch until an aligned redirect
    budget = 5;
    h0     = hs_count;
    redirect(64'h2002);
    check("misaligned_set", 64'(fetch_misaligned), 64'd1);
    repeat (5) tick();
    check("halt_no_reqs", 64'(hs_count - h0), 64'd0);
    check("halt_req_valid", 64'(imem_req_valid), 64'd0);
    budget = 1;
    expect_fetch(64'h3000);
    redirect(64'h3000);
    check("misaligned_clear", 64'(fetch_misaligned), 64'd0);
    drain("misalign_resume");
`else
    // Without the trap the low PC bits are dropped
    budget = 1;
    expect_fetch(64'h2000);
    redirect(64'h2002);
    check("misaligned_tied", 64'(fetch_misaligned), 64'd0);
    drain("misalign_force");
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
